uart_imem_loader: RTL
=====================

// Module: uart_imem_loader
// PURPOSE
//  Boot-time controller between the UART receiver and the instruction memory.
//  - Packs received bytes, LSB first, into 32-bit words and writes them to
//    consecutive imem addresses.
//  - Stops on a sentinel word.
//  - Holds the core in reset until loading ends, then raises write_done.
//  - Sits in the top-level wrapper, between the uart_rx outputs and the imem write port.
// PARAMETERS
//  ADDR_W      8             imem word-address width
//  MAX_WORDS   256           capacity in words; must not exceed 2**ADDR_W
//  END_WORD    32'hFFFF_FFFF sentinel marking end of program; never written
//  BYTE_TMO    1_000_000     idle clks allowed between bytes of one word; 0 = disabled
// PORTS
//  clk           in   1       system clock
//  resetn        in   1       synchronous active-low reset
//  load_en       in   1       loader enable (uart_rx_en); low aborts an in-progress load
//  rx_valid      in   1       1-clk pulse: rx_data holds a new byte
//  rx_data       in   8       received byte
//  rx_break      in   1       UART BREAK detected
//  imem_we       out  1       imem write strobe, 1 clk per word
//  imem_addr     out  ADDR_W  imem word address
//  imem_wdata    out  32      assembled instruction word
//  write_done    out  1       load complete; sticky until resetn
//  cpu_resetn    out  1       active-low core reset; 0 until write_done
//  word_count    out  ADDR_W+1  words written so far
//  frame_err     out  1       sticky: partial word discarded (timeout or break)
//  overflow_err  out  1       sticky: MAX_WORDS written without sentinel
// BEHAVIOUR
//  Reset (resetn=0 at posedge): state=IDLE, byte_idx=0, addr=0, all outputs 0.
//  - This includes cpu_resetn=0, so the core is held in reset.
//  States:
//  - IDLE:    load_en=1 -> COLLECT. rx_valid is ignored in IDLE.
//  - COLLECT: on rx_valid, store rx_data into byte lane byte_idx; byte_idx++.
//             The 4th byte (byte_idx=3) goes to WRITE, or to DONE if the word == END_WORD.
//  - WRITE:   1 clk; imem_we=1, imem_addr=addr, imem_wdata=word.
//             Next clk: addr++ and word_count++.
//             If word_count then equals MAX_WORDS -> DONE with overflow_err=1; else -> COLLECT.
//             An rx_valid during WRITE is accepted as byte 0 of the next word.
//  - DONE:    write_done=1, cpu_resetn=1. All rx activity and load_en are ignored until resetn.
//  Latency:
//  - imem_we is asserted exactly 1 clk after the rx_valid of the 4th byte.
//  - write_done rises 1 clk after the rx_valid of the sentinel's 4th byte.
//  imem_we is 0 outside WRITE. imem_addr and imem_wdata hold their values between writes.
//  Byte order: 1st byte -> [7:0], 2nd -> [15:8], 3rd -> [23:16], 4th -> [31:24].
//  Timeout: in COLLECT with byte_idx!=0, BYTE_TMO clks without rx_valid causes:
//  - byte_idx -> 0, frame_err=1, and the partial word is discarded.
//  - The counter reloads on every accepted byte.
//  rx_break in COLLECT/WRITE: same discard as a timeout.
//  - If it coincides with rx_valid, the break wins and the byte is dropped.
//  load_en low in COLLECT: -> IDLE; byte_idx=0, addr=0, word_count=0. Sticky flags are kept.
//  Words equal to 32'h0 are ordinary data and are written.
//  Address never wraps: overflow ends the load before addr exceeds MAX_WORDS-1.
// TESTING
//  1. Bytes 23,22,F4,FE then FF x4:
//     -> one write, addr 0, data FEF42223; write_done and cpu_resetn rise 1 clk
//        after the last FF; word_count=1.
//  2. Words 00000000, 00000000, FE042783 sent as 12 bytes:
//     -> imem_we pulses at addr 0,1,2 with the correct data; each pulse is 1 clk wide
//        and lands 1 clk after the 4th byte.
//  3. Bytes 13,97 then a (BYTE_TMO+1)-clk gap, then 93,97,17,00:
//     -> frame_err=1; single write of 00179793 at addr 0.
//  4. MAX_WORDS=4, five non-sentinel words:
//     -> 4 writes (addr 0..3), overflow_err=1, write_done=1; 5th word ignored.
//  5. load_en dropped after 2 bytes, re-raised, then 1 full word:
//     -> write at addr 0 with the new word only.
//     resetn pulsed mid-word -> every output returns to its reset value.
//  6. Sentinel received, then further bytes sent -> no imem_we; write_done stays 1.

Source files
------------

// File: rtl/uart_imem_loader.sv
// uart_imem_loader
// Boot-time loader sitting between the UART receiver and the instruction
// memory write port. Received bytes are packed LSB first into 32-bit words
// and written to consecutive imem word addresses. A sentinel word ends the
// load; the core is held in reset (cpu_resetn=0) until the load is done.
//
// Ports
//   clk           system clock
//   resetn        synchronous active-low reset
//   load_en       loader enable; low aborts a load in progress
//   rx_valid      1-clk strobe, rx_data holds a new byte
//   rx_data       received byte
//   rx_break      UART BREAK detected; discards the partial word
//   imem_we       imem write strobe, one clock per word
//   imem_addr     imem word address (held between writes)
//   imem_wdata    assembled word (held between writes)
//   write_done    load complete, sticky until resetn
//   cpu_resetn    active-low core reset, released with write_done
//   word_count    words written so far
//   frame_err     sticky: a partial word was discarded
//   overflow_err  sticky: capacity reached without a sentinel
module uart_imem_loader #(
  parameter int          ADDR_W    = 8,
  parameter int          MAX_WORDS = 256,
  parameter logic [31:0] END_WORD  = 32'hFFFF_FFFF,
  parameter int          BYTE_TMO  = 1_000_000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load_en,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_break,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              write_done,
  output logic              cpu_resetn,
  output logic [ADDR_W:0]   word_count,
  output logic              frame_err,
  output logic              overflow_err
);

  localparam int              TMO_W    = (BYTE_TMO > 1) ? $clog2(BYTE_TMO) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((BYTE_TMO > 0) ? BYTE_TMO - 1 : 0);
  localparam logic [ADDR_W:0] MAX_CNT  = (ADDR_W + 1)'(MAX_WORDS);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t            state_reg, state_next;
  logic [1:0]        byte_idx_reg, byte_idx_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic [TMO_W-1:0]  tmo_reg, tmo_next;
  logic [ADDR_W-1:0] waddr_reg, waddr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic              done_reg, done_next;
  logic              frame_reg, frame_next;
  logic              ovf_reg, ovf_next;
  logic [2:0]        lane_we;
  logic [7:0]        lane_reg [3];
  logic [31:0]       full_word;

  // The 4th byte is never stored: it is merged straight into the word.
  assign full_word = {rx_data, lane_reg[2], lane_reg[1], lane_reg[0]};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (!resetn) lane_reg[gi] <= '0;
        else if (lane_we[gi]) lane_reg[gi] <= rx_data;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      byte_idx_reg <= '0;
      addr_reg     <= '0;
      count_reg    <= '0;
      tmo_reg      <= '0;
      waddr_reg    <= '0;
      wdata_reg    <= '0;
      done_reg     <= 1'b0;
      frame_reg    <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      byte_idx_reg <= byte_idx_next;
      addr_reg     <= addr_next;
      count_reg    <= count_next;
      tmo_reg      <= tmo_next;
      waddr_reg    <= waddr_next;
      wdata_reg    <= wdata_next;
      done_reg     <= done_next;
      frame_reg    <= frame_next;
      ovf_reg      <= ovf_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    byte_idx_next = byte_idx_reg;
    addr_next     = addr_reg;
    count_next    = count_reg;
    tmo_next      = tmo_reg;
    waddr_next    = waddr_reg;
    wdata_next    = wdata_reg;
    done_next     = done_reg;
    frame_next    = frame_reg;
    ovf_next      = ovf_reg;
    lane_we       = '0;
    case (state_reg)
      IDLE: begin
        if (load_en) state_next = COLLECT;
      end
      COLLECT: begin
        if (!load_en) begin
          state_next    = IDLE;
          byte_idx_next = '0;
          addr_next     = '0;
          count_next    = '0;
          tmo_next      = '0;
        end else if (rx_break) begin
          byte_idx_next = '0;
          tmo_next      = '0;
          frame_next    = 1'b1;
        end else if (rx_valid) begin
          tmo_next = '0;
          if (byte_idx_reg == 2'd3) begin
            byte_idx_next = '0;
            if (full_word == END_WORD) begin
              state_next = DONE;
              done_next  = 1'b1;
            end else begin
              state_next = WRITE;
              waddr_next = addr_reg;
              wdata_next = full_word;
            end
          end else begin
            byte_idx_next = byte_idx_reg + 2'd1;
            case (byte_idx_reg)
              2'd0:    lane_we[0] = 1'b1;
              2'd1:    lane_we[1] = 1'b1;
              2'd2:    lane_we[2] = 1'b1;
              default: lane_we    = '0;
            endcase
          end
        end else if (BYTE_TMO != 0 && byte_idx_reg != 2'd0) begin
          // Idle gap inside a word: after BYTE_TMO quiet clocks drop the partial word.
          if (tmo_reg == TMO_LAST) begin
            byte_idx_next = '0;
            tmo_next      = '0;
            frame_next    = 1'b1;
          end else begin
            tmo_next = tmo_reg + TMO_W'(1);
          end
        end
      end
      WRITE: begin
        addr_next  = addr_reg + ADDR_W'(1);
        count_next = count_reg + (ADDR_W + 1)'(1);
        if (count_reg + (ADDR_W + 1)'(1) == MAX_CNT) begin
          state_next = DONE;
          done_next  = 1'b1;
          ovf_next   = 1'b1;
        end else begin
          state_next = COLLECT;
          // A byte arriving during the write strobe starts the next word.
          if (rx_break) begin
            byte_idx_next = '0;
            frame_next    = 1'b1;
          end else if (rx_valid) begin
            lane_we[0]    = 1'b1;
            byte_idx_next = 2'd1;
            tmo_next      = '0;
          end
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign imem_we      = (state_reg == WRITE);
  assign imem_addr    = waddr_reg;
  assign imem_wdata   = wdata_reg;
  assign write_done   = done_reg;
  assign cpu_resetn   = done_reg;
  assign word_count   = count_reg;
  assign frame_err    = frame_reg;
  assign overflow_err = ovf_reg;

endmodule
